m_serial_sched: RTL and testbench

Scheduler and sequencer for the shared bit-serial adder/subtractor. Two independent requesters compete for one WIDTH-bit shift-register datapath, which adds one bit per clock. The block arbitrates round-robin, latches the winner's operands, and runs the datapath for exactly WIDTH cycles. It then returns the result and carry to the winning port with a one-cycle done pulse. It sits between the m_main front-end logic and the serial adder core, which is folded into this block.

---
 rtl/m_serial_sched.sv | 140 ++++++++++++++
 tb/tb_m_serial_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/m_serial_sched.sv
// Round-robin scheduler wrapped around a bit-serial add/subtract datapath.
// Two ports share one WIDTH-bit shifter; each operation takes WIDTH clocks.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | datapath free; a pending request is granted on this edge
// S_RUN  | shifting one sum bit per clock for the latched winner
module m_serial_sched #(
   parameter int WIDTH = 32
) (
   input  logic             w_clk,
   input  logic             w_rst,
   input  logic [1:0]       w_req,
   input  logic [WIDTH-1:0] w_a0,
   input  logic [WIDTH-1:0] w_b0,
   input  logic [WIDTH-1:0] w_a1,
   input  logic [WIDTH-1:0] w_b1,
   input  logic [1:0]       w_sub,
   output logic [1:0]       r_gnt,
   output logic             r_busy,
   output logic [1:0]       r_done,
   output logic [WIDTH-1:0] r_rslt,
   output logic             r_cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             id_q, id_d;
   logic             last_q, last_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       done_q, done_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] rslt_q, rslt_d;
   logic             cout_q, cout_d;

   logic             win;
   logic             sub_sel;
   logic [WIDTH-1:0] b_sel;
   logic             sum_bit;
   logic             maj_bit;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      last_d  = last_q;
      gnt_d   = 2'b00;
      done_d  = 2'b00;
      busy_d  = busy_q;
      rslt_d  = rslt_q;
      cout_d  = cout_q;

      // On a tie the port that was not served last wins.
      win     = (w_req == 2'b11) ? ~last_q : w_req[1];
      sub_sel = win ? w_sub[1] : w_sub[0];
      b_sel   = win ? w_b1 : w_b0;
      sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
      maj_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

      case (state_q)
         S_IDLE: begin
            if (|w_req) begin
               a_d     = win ? w_a1 : w_a0;
               b_d     = sub_sel ? ~b_sel : b_sel;
               carry_d = sub_sel;
               cnt_d   = '0;
               id_d    = win;
               last_d  = win;
               gnt_d   = win ? 2'b10 : 2'b01;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d     = {sum_bit, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = maj_bit;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               rslt_d  = {sum_bit, a_q[WIDTH-1:1]};
               cout_d  = maj_bit;
               done_d  = id_q ? 2'b10 : 2'b01;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         busy_q  <= 1'b0;
         rslt_q  <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         rslt_q  <= rslt_d;
         cout_q  <= cout_d;
      end
   end

   assign r_gnt  = gnt_q;
   assign r_done = done_q;
   assign r_busy = busy_q;
   assign r_rslt = rslt_q;
   assign r_cout = cout_q;

endmodule

// File: tb/tb_m_serial_sched.sv
// Scoreboard bench for m_serial_sched: grants push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_m_serial_sched;

   logic        clk = 1'b0;
   logic        w_rst;
   logic [1:0]  w_req;
   logic [31:0] w_a0, w_b0, w_a1, w_b1;
   logic [1:0]  w_sub;
   logic [1:0]  r_gnt;
   logic        r_busy;
   logic [1:0]  r_done;
   logic [31:0] r_rslt;
   logic        r_cout;

   always #5 clk = ~clk;

   m_serial_sched #(.WIDTH(32)) dut (
      .w_clk (clk),
      .w_rst (w_rst),
      .w_req (w_req),
      .w_a0  (w_a0),
      .w_b0  (w_b0),
      .w_a1  (w_a1),
      .w_b1  (w_b1),
      .w_sub (w_sub),
      .r_gnt (r_gnt),
      .r_busy(r_busy),
      .r_done(r_done),
      .r_rslt(r_rslt),
      .r_cout(r_cout)
   );

   typedef struct {
      logic        port;
      logic [31:0] rslt;
      logic        cout;
      int          gcyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   busy_run = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // Monitor: busy length, no gnt/done overlap, and scoreboard compare.
   always @(negedge clk) begin
      if (r_busy) busy_run++;
      else begin
         if (r_done != 2'b00) chk("busy_len", 64'(busy_run), 64'd32);
         busy_run = 0;
      end
      if (r_done != 2'b00) begin
         chk("gnt_done_overlap", 64'(r_gnt), 64'd0);
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got r_done=%b expected none", r_done);
         end else begin
            e = sb.pop_front();
            chk("done_port", 64'(r_done), e.port ? 64'd2 : 64'd1);
            chk("rslt", 64'(r_rslt), 64'(e.rslt));
            chk("cout", 64'(r_cout), 64'(e.cout));
            chk("latency", 64'(cyc - e.gcyc), 64'd32);
         end
      end
   end

   task automatic wait_gnt(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (r_gnt != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL gnt_timeout: got no grant expected one within 100 cycles");
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run_op(input logic port, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] er, input logic ec,
                         input logic hold);
      logic ok;
      exp_t x;
      @(negedge clk);
      if (port) begin w_a1 = a; w_b1 = b; end
      else      begin w_a0 = a; w_b0 = b; end
      w_sub[port] = sub;
      w_req = port ? 2'b10 : 2'b01;
      wait_gnt(ok);
      w_req = 2'b00;
      if (ok) begin
         chk("gnt", 64'(r_gnt), port ? 64'd2 : 64'd1);
         chk("busy_at_gnt", 64'(r_busy), 64'd1);
         x.port = port; x.rslt = er; x.cout = ec; x.gcyc = cyc;
         sb.push_back(x);
         if (hold) begin
            for (int i = 0; i < 25; i++) begin
               @(negedge clk);
               w_a0 = $urandom;
               w_b0 = $urandom;
               w_sub[0] = ~w_sub[0];
            end
         end
         wait_drain();
      end
   endtask

   initial begin
      logic ok;
      int   prev;
      exp_t x;
      w_rst = 1'b1;
      w_req = 2'b11;
      w_a0 = 32'd1;  w_b0 = 32'd2;
      w_a1 = 32'd10; w_b1 = 32'd3;
      w_sub = 2'b10;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 64'(r_gnt), 64'd0);
      chk("rst_busy", 64'(r_busy), 64'd0);
      chk("rst_done", 64'(r_done), 64'd0);
      chk("rst_rslt", 64'(r_rslt), 64'd0);
      chk("rst_cout", 64'(r_cout), 64'd0);
      w_rst = 1'b0;

      // Both ports request continuously: 1+2=3 on port 0, 10-3=7 on port 1.
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(ok);
         if (!ok) break;
         chk("arb_gnt", 64'(r_gnt), (k % 2) ? 64'd2 : 64'd1);
         if (k > 0) chk("gnt_spacing", 64'(cyc - prev), 64'd33);
         prev = cyc;
         x.port = (k % 2) != 0;
         x.rslt = (k % 2) ? 32'd7 : 32'd3;
         x.cout = (k % 2) != 0;
         x.gcyc = cyc;
         sb.push_back(x);
         if (k == 3) w_req = 2'b00;
      end
      wait_drain();

      run_op(1'b1, 32'd7, 32'd6, 1'b1, 32'd1, 1'b1, 1'b0);
      run_op(1'b1, 32'd6, 32'd7, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op(1'b0, 32'd6, 32'd7, 1'b0, 32'd13, 1'b0, 1'b0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0);
      run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 1'b1, 1'b0);
      run_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b1);

      // Abort an operation with reset at RUN cycle 10.
      @(negedge clk);
      w_a0 = 32'd100; w_b0 = 32'd23; w_sub = 2'b00; w_req = 2'b01;
      wait_gnt(ok);
      w_req = 2'b00;
      repeat (9) @(negedge clk);
      w_rst = 1'b1;
      @(negedge clk);
      w_rst = 1'b0;
      chk("abort_busy", 64'(r_busy), 64'd0);
      chk("abort_gnt", 64'(r_gnt), 64'd0);
      chk("abort_done", 64'(r_done), 64'd0);
      chk("abort_rslt", 64'(r_rslt), 64'd0);
      chk("abort_cout", 64'(r_cout), 64'd0);
      repeat (40) @(negedge clk);
      run_op(1'b0, 32'd100, 32'd23, 1'b0, 32'd123, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule
